station_sched: RTL and testbench

- Destination scheduler between UART_rcv and cmd_cntrl.
- Accepts a queue of "go to station" commands from the UART and issues them to cmd_cntrl one at a time.
- Issues the next command only after the previous trip ends and a dwell time at the station has elapsed.
- A stop command flushes the queue and preempts the current trip.

---
 rtl/station_sched.sv | 176 +++++++++++++++++
 tb/tb_station_sched.sv | 378 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/station_sched.sv
// station_sched: destination scheduler between UART_rcv and cmd_cntrl.
// Queues "go to station" commands and hands them to cmd_cntrl one at a
// time. Each destination is issued only after the previous trip has ended
// and the dwell time at the station has elapsed. A stop command flushes the
// queue and preempts whatever trip is in progress.
//
// Handshakes:
//   UART side : cmd is valid while cmd_rdy is high; the byte is consumed by
//               a one-cycle clr_cmd_rdy pulse registered the cycle after it
//               is taken. cmd_rdy is ignored during that pulse cycle.
//   cmd_cntrl : fwd_cmd is valid while fwd_rdy is high; fwd_rdy is a level
//               held until cmd_cntrl answers with fwd_clr. fwd_cmd keeps
//               its last value while fwd_rdy is low.
module station_sched #(
    parameter int DEPTH = 4,
    parameter int DWELL = 50000
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [7:0]               cmd,
    input  logic                     cmd_rdy,
    output logic                     clr_cmd_rdy,
    output logic [7:0]               fwd_cmd,
    output logic                     fwd_rdy,
    input  logic                     fwd_clr,
    input  logic                     in_transit,
    output logic [$clog2(DEPTH):0]   q_cnt,
    output logic                     q_full,
    output logic                     drop,
    output logic                     busy
);

    localparam int PW = $clog2(DEPTH);
    localparam int QW = $clog2(DEPTH) + 1;
    localparam int CW = $clog2(DWELL + 1);

    localparam logic [QW-1:0] Q_MAX      = QW'(DEPTH);
    localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL - 1);

    localparam logic [2:0] S_IDLE       = 3'd0;
    localparam logic [2:0] S_ISSUE      = 3'd1;
    localparam logic [2:0] S_WAIT_START = 3'd2;
    localparam logic [2:0] S_TRANSIT    = 3'd3;
    localparam logic [2:0] S_DWELL      = 3'd4;
    localparam logic [2:0] S_STOP_ISSUE = 3'd5;

    logic [5:0]    mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [2:0]    state;
    logic [CW-1:0] dwell_cnt;

    logic take;
    logic is_go;
    logic is_stop;
    logic pop;
    logic push;

    // A byte is taken only outside the clear cycle, so it is never read twice.
    assign take    = cmd_rdy && !clr_cmd_rdy;
    assign is_go   = take && (cmd[7:6] == 2'b01);
    assign is_stop = take && (cmd[7:6] == 2'b00);

    // A stop in the same cycle cancels the IDLE pop.
    assign pop  = (state == S_IDLE) && (q_cnt != '0) && !is_stop;
    // A full queue still accepts when the head leaves in the same cycle.
    assign push = is_go && ((q_cnt < Q_MAX) || pop);

    assign q_full = (q_cnt == Q_MAX);
    assign busy   = (state != S_IDLE);

    // UART intake: clear pulse for every taken byte, drop pulse for a rejected go.
    always_ff @(posedge clk) begin
        if (rst) begin
            clr_cmd_rdy <= 1'b0;
            drop        <= 1'b0;
        end else begin
            clr_cmd_rdy <= take;
            drop        <= is_go && !push;
        end
    end

    // Queue storage; contents are don't-care until the count covers them.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= cmd[5:0];
        end
    end

    // Queue pointers and occupancy; a stop flushes by equalizing the pointers.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            q_cnt  <= '0;
        end else if (is_stop) begin
            rd_ptr <= wr_ptr;
            q_cnt  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            if (push && !pop) begin
                q_cnt <= q_cnt + QW'(1);
            end else if (pop && !push) begin
                q_cnt <= q_cnt - QW'(1);
            end
        end
    end

    // Trip sequencing FSM with the forward handshake and dwell timer.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            fwd_cmd   <= 8'h00;
            fwd_rdy   <= 1'b0;
            dwell_cnt <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (pop) begin
                        fwd_cmd <= {2'b01, mem[rd_ptr]};
                        fwd_rdy <= 1'b1;
                        state   <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (is_stop) begin
                        // fwd_rdy stays high; only the payload changes.
                        fwd_cmd <= 8'h00;
                        state   <= S_STOP_ISSUE;
                    end else if (fwd_clr) begin
                        fwd_rdy <= 1'b0;
                        state   <= S_WAIT_START;
                    end
                end
                S_WAIT_START, S_TRANSIT, S_DWELL: begin
                    if (is_stop) begin
                        fwd_cmd <= 8'h00;
                        fwd_rdy <= 1'b1;
                        state   <= S_STOP_ISSUE;
                    end else if (state == S_WAIT_START) begin
                        if (in_transit) begin
                            state <= S_TRANSIT;
                        end
                    end else if (state == S_TRANSIT) begin
                        if (!in_transit) begin
                            dwell_cnt <= '0;
                            state     <= S_DWELL;
                        end
                    end else begin
                        if (dwell_cnt == DWELL_LAST) begin
                            state <= S_IDLE;
                        end else begin
                            dwell_cnt <= dwell_cnt + CW'(1);
                        end
                    end
                end
                S_STOP_ISSUE: begin
                    if (fwd_clr) begin
                        fwd_rdy <= 1'b0;
                        state   <= S_IDLE;
                    end
                end
                default: begin
                    fwd_rdy <= 1'b0;
                    state   <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_station_sched.sv
// Bench for station_sched: directed scenarios plus randomized go/ignored
// traffic checked against a queue model of pending destinations.
module tb_station_sched;

    localparam int DEPTH_P = 4;
    localparam int DWELL_P = 100;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] cmd;
    logic       cmd_rdy;
    logic       clr_cmd_rdy;
    logic [7:0] fwd_cmd;
    logic       fwd_rdy;
    logic       fwd_clr;
    logic       in_transit;
    logic [2:0] q_cnt;
    logic       q_full;
    logic       drop;
    logic       busy;

    int vectors     = 0;
    int miscompares = 0;

    // Pending destinations (excludes the active one).
    logic [5:0] exp_q[$];

    // Snapshots taken by send_byte.
    logic       s_rdy0, s_rdy1, s_rdy2;
    logic       s_clr1, s_clr2, s_drop1, s_drop2, s_full1, s_busy1;
    logic [7:0] s_fcmd1;
    logic [2:0] s_qcnt1;

    station_sched #(.DEPTH(DEPTH_P), .DWELL(DWELL_P)) dut (
        .clk         (clk),
        .rst         (rst),
        .cmd         (cmd),
        .cmd_rdy     (cmd_rdy),
        .clr_cmd_rdy (clr_cmd_rdy),
        .fwd_cmd     (fwd_cmd),
        .fwd_rdy     (fwd_rdy),
        .fwd_clr     (fwd_clr),
        .in_transit  (in_transit),
        .q_cnt       (q_cnt),
        .q_full      (q_full),
        .drop        (drop),
        .busy        (busy)
    );

    // Clock and watchdog.
    always #5 clk = ~clk;

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Driver: present one UART byte; optionally keep cmd_rdy high through the
    // clear cycle. Samples outputs on negedges around the transfer.
    task automatic send_byte(input logic [7:0] b, input bit hold);
        @(negedge clk);
        s_rdy0  = fwd_rdy;
        cmd     = b;
        cmd_rdy = 1'b1;
        @(negedge clk);
        s_clr1  = clr_cmd_rdy;
        s_drop1 = drop;
        s_qcnt1 = q_cnt;
        s_full1 = q_full;
        s_rdy1  = fwd_rdy;
        s_fcmd1 = fwd_cmd;
        s_busy1 = busy;
        if (!hold) cmd_rdy = 1'b0;
        @(negedge clk);
        s_clr2  = clr_cmd_rdy;
        s_drop2 = drop;
        s_rdy2  = fwd_rdy;
        cmd_rdy = 1'b0;
    endtask

    // Wait for the next destination, check it, consume it and start moving.
    task automatic start_trip(input logic [5:0] dest);
        int k = 0;
        while (fwd_rdy !== 1'b1 && k < DWELL_P + 20) begin
            @(negedge clk);
            k++;
        end
        vectors++;
        if (fwd_rdy !== 1'b1 || fwd_cmd !== {2'b01, dest}) begin
            miscompares++;
            $display("FAIL issue: got rdy=%b cmd=%h expected rdy=1 cmd=%h", fwd_rdy, fwd_cmd, {2'b01, dest});
        end
        vectors++;
        if (busy !== 1'b1) begin
            miscompares++;
            $display("FAIL issue_busy: got %b expected 1", busy);
        end
        fwd_clr = 1'b1;
        @(negedge clk);
        fwd_clr    = 1'b0;
        in_transit = 1'b1;
        vectors++;
        if (fwd_rdy !== 1'b0) begin
            miscompares++;
            $display("FAIL consume: fwd_rdy got %b expected 0", fwd_rdy);
        end
        @(negedge clk);
    endtask

    // End the current trip; measure cycles until the next issue or until idle.
    task automatic end_trip(input bit expect_next);
        int  k = 0;
        bit  got = 0;
        bit  stray = 0;
        int  exp_k;
        exp_k = expect_next ? DWELL_P + 2 : DWELL_P + 1;
        @(negedge clk);
        in_transit = 1'b0;
        while (!got && k < 3 * DWELL_P) begin
            @(negedge clk);
            k++;
            if (expect_next ? (fwd_rdy === 1'b1) : (busy === 1'b0)) got = 1;
        end
        vectors++;
        if (!got || k != exp_k) begin
            miscompares++;
            $display("FAIL dwell_gap: got %0d cycles (seen=%0d) expected %0d", k, got, exp_k);
        end
        if (!expect_next) begin
            vectors++;
            if (q_cnt !== 3'd0) begin
                miscompares++;
                $display("FAIL idle_qcnt: got %0d expected 0", q_cnt);
            end
            repeat (20) begin
                @(negedge clk);
                if (fwd_rdy !== 1'b0 || busy !== 1'b0) stray = 1;
            end
            vectors++;
            if (stray) begin
                miscompares++;
                $display("FAIL stray_issue: got activity while idle expected none");
            end
        end
    endtask

    // Serve every queued destination in order, then go idle.
    task automatic drain();
        while (exp_q.size() > 0) begin
            end_trip(1'b1);
            start_trip(exp_q.pop_front());
        end
        end_trip(1'b0);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        vectors++;
        if ({clr_cmd_rdy, fwd_cmd, fwd_rdy, q_cnt, q_full, drop, busy} !== 16'h0) begin
            miscompares++;
            $display("FAIL reset_outputs: got %h expected 0000",
                     {clr_cmd_rdy, fwd_cmd, fwd_rdy, q_cnt, q_full, drop, busy});
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_single_trip();
        send_byte(8'h42, 1'b0);
        vectors++;
        if (s_clr1 !== 1'b1 || s_clr2 !== 1'b0) begin
            miscompares++;
            $display("FAIL clr_pulse: got %b%b expected 10", s_clr1, s_clr2);
        end
        vectors++;
        if (s_drop1 !== 1'b0) begin
            miscompares++;
            $display("FAIL single_drop: got %b expected 0", s_drop1);
        end
        start_trip(6'h02);
        repeat (500) @(negedge clk);
        end_trip(1'b0);
    endtask

    task automatic test_queue_wrap();
        logic [7:0] seq [4];
        seq = '{8'h43, 8'h45, 8'h47, 8'h49};
        send_byte(8'h41, 1'b0);
        start_trip(6'h01);
        for (int i = 0; i < 4; i++) begin
            send_byte(seq[i], i == 1);
            exp_q.push_back(seq[i][5:0]);
            vectors++;
            if (s_qcnt1 !== 3'(exp_q.size()) || s_drop1 !== 1'b0 || s_clr1 !== 1'b1) begin
                miscompares++;
                $display("FAIL enqueue: got q_cnt=%0d drop=%b clr=%b expected q_cnt=%0d drop=0 clr=1",
                         s_qcnt1, s_drop1, s_clr1, exp_q.size());
            end
        end
        vectors++;
        if (s_full1 !== 1'b1) begin
            miscompares++;
            $display("FAIL q_full: got %b expected 1", s_full1);
        end
        test_overflow();
        drain();
    endtask

    task automatic test_overflow();
        send_byte(8'h4A, 1'b0);
        vectors++;
        if (s_drop1 !== 1'b1 || s_drop2 !== 1'b0) begin
            miscompares++;
            $display("FAIL drop_pulse: got %b%b expected 10", s_drop1, s_drop2);
        end
        vectors++;
        if (s_qcnt1 !== 3'd4) begin
            miscompares++;
            $display("FAIL overflow_qcnt: got %0d expected 4", s_qcnt1);
        end
    endtask

    task automatic test_stop_mid_trip();
        logic [5:0] d;
        d = 6'($urandom);
        send_byte({2'b01, d}, 1'b0);
        start_trip(d);
        repeat (2) begin
            d = 6'($urandom);
            send_byte({2'b01, d}, 1'b0);
            exp_q.push_back(d);
        end
        vectors++;
        if (s_qcnt1 !== 3'd2) begin
            miscompares++;
            $display("FAIL stop_pre_qcnt: got %0d expected 2", s_qcnt1);
        end
        send_byte(8'h00, 1'b0);
        exp_q.delete();
        vectors++;
        if (s_qcnt1 !== 3'd0 || s_rdy1 !== 1'b1 || s_fcmd1 !== 8'h00) begin
            miscompares++;
            $display("FAIL stop_fwd: got q_cnt=%0d rdy=%b cmd=%h expected q_cnt=0 rdy=1 cmd=00",
                     s_qcnt1, s_rdy1, s_fcmd1);
        end
        in_transit = 1'b0;
        fwd_clr    = 1'b1;
        @(negedge clk);
        fwd_clr = 1'b0;
        repeat (5) @(negedge clk);
        vectors++;
        if (fwd_rdy !== 1'b0 || busy !== 1'b0 || q_cnt !== 3'd0) begin
            miscompares++;
            $display("FAIL stop_idle: got rdy=%b busy=%b q_cnt=%0d expected 0 0 0", fwd_rdy, busy, q_cnt);
        end
    endtask

    task automatic test_stop_issue();
        logic [5:0] d;
        // Stop and ignored bytes while idle: cleared, nothing forwarded.
        send_byte(8'h00, 1'b0);
        vectors++;
        if (s_clr1 !== 1'b1 || s_rdy1 !== 1'b0 || s_busy1 !== 1'b0) begin
            miscompares++;
            $display("FAIL idle_stop: got clr=%b rdy=%b busy=%b expected 1 0 0", s_clr1, s_rdy1, s_busy1);
        end
        send_byte(8'h45, 1'b0);
        vectors++;
        if (s_rdy2 !== 1'b1 || fwd_cmd !== 8'h45) begin
            miscompares++;
            $display("FAIL issue_45: got rdy=%b cmd=%h expected 1 45", s_rdy2, fwd_cmd);
        end
        send_byte(8'h00, 1'b0);
        vectors++;
        if (s_rdy0 !== 1'b1 || s_rdy1 !== 1'b1 || s_rdy2 !== 1'b1 || s_fcmd1 !== 8'h00) begin
            miscompares++;
            $display("FAIL stop_in_issue: got rdy=%b%b%b cmd=%h expected 111 00", s_rdy0, s_rdy1, s_rdy2, s_fcmd1);
        end
        send_byte(8'hC0, 1'b0);
        vectors++;
        if (s_clr1 !== 1'b1 || s_qcnt1 !== 3'd0 || s_drop1 !== 1'b0 || s_fcmd1 !== 8'h00) begin
            miscompares++;
            $display("FAIL ignored_c0: got clr=%b q_cnt=%0d drop=%b cmd=%h expected 1 0 0 00",
                     s_clr1, s_qcnt1, s_drop1, s_fcmd1);
        end
        d = 6'($urandom);
        send_byte({2'b01, d}, 1'b0);
        vectors++;
        if (s_qcnt1 !== 3'd1 || s_rdy1 !== 1'b1 || s_fcmd1 !== 8'h00) begin
            miscompares++;
            $display("FAIL go_in_stop: got q_cnt=%0d rdy=%b cmd=%h expected 1 1 00", s_qcnt1, s_rdy1, s_fcmd1);
        end
        fwd_clr = 1'b1;
        @(negedge clk);
        fwd_clr = 1'b0;
        vectors++;
        if (fwd_rdy !== 1'b0) begin
            miscompares++;
            $display("FAIL stop_consume: fwd_rdy got %b expected 0", fwd_rdy);
        end
        start_trip(d);
        end_trip(1'b0);
    endtask

    task automatic test_reset_mid_dwell();
        send_byte(8'h42, 1'b0);
        start_trip(6'h02);
        send_byte({2'b01, 6'($urandom)}, 1'b0);
        in_transit = 1'b0;
        repeat (30) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        vectors++;
        if ({clr_cmd_rdy, fwd_cmd, fwd_rdy, q_cnt, q_full, drop, busy} !== 16'h0) begin
            miscompares++;
            $display("FAIL reset_dwell: got %h expected 0000",
                     {clr_cmd_rdy, fwd_cmd, fwd_rdy, q_cnt, q_full, drop, busy});
        end
        rst = 1'b0;
        exp_q.delete();
        send_byte(8'h42, 1'b0);
        start_trip(6'h02);
        repeat (20) @(negedge clk);
        end_trip(1'b0);
    endtask

    task automatic test_random();
        logic [5:0] d;
        logic [7:0] b;
        bit         exp_drop;
        int         exp_cnt;
        for (int r = 0; r < 5; r++) begin
            d = 6'($urandom);
            send_byte({2'b01, d}, 1'b0);
            start_trip(d);
            for (int i = 0; i < int'($urandom_range(2, 7)); i++) begin
                exp_drop = 1'b0;
                if ($urandom_range(0, 4) == 0) begin
                    b = {1'b1, 7'($urandom)};
                end else begin
                    b = {2'b01, 6'($urandom)};
                    if (exp_q.size() < DEPTH_P) exp_q.push_back(b[5:0]);
                    else exp_drop = 1'b1;
                end
                send_byte(b, $urandom_range(0, 1) == 1);
                exp_cnt = exp_q.size();
                vectors++;
                if (s_qcnt1 !== 3'(exp_cnt) || s_drop1 !== exp_drop || s_full1 !== (exp_cnt == DEPTH_P)) begin
                    miscompares++;
                    $display("FAIL rand_intake: byte %h got q_cnt=%0d drop=%b full=%b expected q_cnt=%0d drop=%b",
                             b, s_qcnt1, s_drop1, s_full1, exp_cnt, exp_drop);
                end
            end
            repeat ($urandom_range(0, 10)) @(negedge clk);
            drain();
        end
    endtask

    initial begin
        rst        = 1'b1;
        cmd        = 8'h00;
        cmd_rdy    = 1'b0;
        fwd_clr    = 1'b0;
        in_transit = 1'b0;
        test_reset();
        test_single_trip();
        test_queue_wrap();
        test_stop_mid_trip();
        test_stop_issue();
        test_reset_mid_dwell();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
